alu_mc: RTL

Parametrised multi-cycle successor to the single-cycle RISC-V ALU. It generalises datapath width and extends the operation set to shifts, unsigned compare, multiply and divide/remainder (RV32IM-style subset). Operands arrive and results leave through valid/ready handshakes. Simple operations complete in one cycle; multiply and divide are iterative. The block sits in the execute stage of the multi-cycle/pipelined core, which stalls on `in_ready`/`out_valid`.

---
 rtl/alu_mc.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle RV32IM-style ALU with valid/ready handshakes
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             Zero
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    st_idle,
    st_mul,
    st_div,
    st_fix,
    st_done
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic [3:0]       op;
  logic [SW-1:0]    cnt;
  logic             last_iter;

  // single-cycle / short-circuit result
  logic [WIDTH-1:0] quick;
  logic             quick_ok;
  logic [SW-1:0]    shamt;
  logic             bzero;
  logic             ovf;

  // shift-add multiplier: prod = {accumulator, remaining multiplier bits}
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     mul_sum;

  // restoring divider on magnitudes
  logic [WIDTH-1:0] rem_r, quo_r, dsr;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH:0]   div_part, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_q, neg_r;

  // result register load
  logic             y_load;
  logic [WIDTH-1:0] y_d;

  assign in_ready  = !reset && ((state == st_idle) || (state == st_done && out_ready));
  assign out_valid = (state == st_done);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == SW'(WIDTH - 1));

  assign shamt = b[SW-1:0];
  assign bzero = (b == '0);
  assign ovf   = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // ALUControl[1] marks the signed div/rem codes; only meaningful for 11xx
  assign mag_a = (ALUControl[1] && a[WIDTH-1]) ? -a : a;
  assign mag_b = (ALUControl[1] && b[WIDTH-1]) ? -b : b;

  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_nxt = {mul_sum, prod[WIDTH-1:1]};

  assign div_part  = {rem_r, quo_r[WIDTH-1]};
  assign div_trial = div_part - {1'b0, dsr};
  assign div_ge    = (div_part >= {1'b0, dsr});
  assign rem_nxt   = div_ge ? div_trial[WIDTH-1:0] : div_part[WIDTH-1:0];
  assign quo_nxt   = {quo_r[WIDTH-2:0], div_ge};

  // single-cycle results, plus divide-by-zero and signed-overflow short-circuits
  always_comb begin
    quick    = '0;
    quick_ok = 1'b0;
    case (ALUControl)
      4'b0000: begin quick = a + b; quick_ok = 1'b1; end
      4'b0001: begin quick = a - b; quick_ok = 1'b1; end
      4'b0010: begin quick = a & b; quick_ok = 1'b1; end
      4'b0011: begin quick = a | b; quick_ok = 1'b1; end
      4'b0100: begin quick = a ^ b; quick_ok = 1'b1; end
      4'b0101: begin quick = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))}; quick_ok = 1'b1; end
      4'b0110: begin quick = {{(WIDTH-1){1'b0}}, (a < b)}; quick_ok = 1'b1; end
      4'b0111: begin quick = a << shamt; quick_ok = 1'b1; end
      4'b1000: begin quick = a >> shamt; quick_ok = 1'b1; end
      4'b1001: begin quick = $unsigned($signed(a) >>> shamt); quick_ok = 1'b1; end
      4'b1010: quick_ok = 1'b0;
      4'b1011: quick_ok = 1'b0;
      4'b1100: if (bzero) begin quick = '1; quick_ok = 1'b1; end
      4'b1101: if (bzero) begin quick = a;  quick_ok = 1'b1; end
      4'b1110: begin
        if (bzero)    begin quick = '1; quick_ok = 1'b1; end
        else if (ovf) begin quick = a;  quick_ok = 1'b1; end
      end
      4'b1111: begin
        if (bzero)    begin quick = a;  quick_ok = 1'b1; end
        else if (ovf) begin quick = '0; quick_ok = 1'b1; end
      end
    endcase
  end

  // pick the value to load into y: accepted quick op, last multiply step, or sign fix
  always_comb begin
    y_load = 1'b0;
    y_d    = '0;
    if (accept && quick_ok) begin
      y_load = 1'b1;
      y_d    = quick;
    end else if (state == st_mul && last_iter) begin
      y_load = 1'b1;
      y_d    = op[0] ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
    end else if (state == st_fix) begin
      y_load = 1'b1;
      if (op[0]) y_d = neg_r ? -rem_r : rem_r;
      else       y_d = neg_q ? -quo_r : quo_r;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle, st_done: begin
        if (accept) begin
          if (quick_ok)                  state_nxt = st_done;
          else if (ALUControl[3:2] == 2'b10) state_nxt = st_mul;
          else                           state_nxt = st_div;
        end else if (state == st_done && out_ready) begin
          state_nxt = st_idle;
        end
      end
      st_mul:  if (last_iter) state_nxt = st_done;
      st_div:  if (last_iter) state_nxt = st_fix;
      st_fix:  state_nxt = st_done;
      default: state_nxt = st_idle;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= st_idle;
    else       state <= state_nxt;
  end

  // result register; Zero always moves together with y
  always_ff @(posedge clk) begin
    if (reset) begin
      y    <= '0;
      Zero <= 1'b0;
    end else if (y_load) begin
      y    <= y_d;
      Zero <= (y_d == '0);
    end
  end

  // operand capture and iteration registers; only reach y through y_d
  always_ff @(posedge clk) begin
    if (accept) begin
      op    <= ALUControl;
      cnt   <= '0;
      prod  <= {{WIDTH{1'b0}}, b};
      mcand <= a;
      rem_r <= '0;
      quo_r <= mag_a;
      dsr   <= mag_b;
      neg_q <= ALUControl[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= ALUControl[1] && a[WIDTH-1];
    end else if (state == st_mul) begin
      prod <= prod_nxt;
      cnt  <= cnt + SW'(1);
    end else if (state == st_div) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      cnt   <= cnt + SW'(1);
    end
  end

endmodule
